// File: rtl/node_package.sv
// Shared request-channel types and default sizing for the NoC request links.
package node_package;

    localparam int REQ_BUF_DEPTH = 4;
    localparam int REQ_MAX_CRED  = 8;

    typedef struct packed {
        logic [3:0] src;
        logic [3:0] dst;
        logic [1:0] op;
        logic [5:0] tag;
    } ReqType;

    localparam int REQ_W = $bits(ReqType);

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter with reset value and saturation at MAX; o_ovf flags
// an increment that had to be dropped because the counter was already full.
module credit_counter #(
    parameter int W       = 4,
    parameter int RST_VAL = 0,
    parameter int MAX     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_ovf
);

    logic [W-1:0] r_cnt;
    logic         w_at_max;

    assign w_at_max = (r_cnt == W'(MAX));
    assign o_ovf    = i_inc && !i_dec && w_at_max;
    assign o_cnt    = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= W'(RST_VAL);
        end else if (i_inc && !i_dec) begin
            if (!w_at_max) r_cnt <= r_cnt + W'(1);
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

endmodule

// File: rtl/req_credit_buffer.sv
// Credit-flow-controlled request buffer: absorbs up to DEPTH requests, returns
// freed entries upstream as credit pulses, sends downstream only with credits.
module req_credit_buffer
    import node_package::*;
#(
    parameter int DEPTH       = REQ_BUF_DEPTH,
    parameter int MAX_DN_CRED = REQ_MAX_CRED
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       v_rx_req,
    input  ReqType                     rx_req,
    output logic                       pre_rx_req,
    output logic                       v_tx_req,
    output ReqType                     tx_req,
    input  logic                       pre_tx_req,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic                       err
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    localparam int CW = $clog2(MAX_DN_CRED+1);

    ReqType          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [OW-1:0]   r_occ;
    logic            r_v_tx, r_pre_rx, r_err;
    ReqType          r_tx;

    logic [OW-1:0]   w_ret_cnt;
    logic [CW-1:0]   w_dn_cred;
    logic            w_deq, w_full, w_enq, w_drop, w_ret_dec;
    logic            w_ret_ovf, w_dn_ovf;

    assign w_deq     = (r_occ != '0) && (w_dn_cred != '0);
    assign w_full    = (r_occ == OW'(DEPTH));
    assign w_enq     = v_rx_req && (!w_full || w_deq);
    assign w_drop    = v_rx_req && w_full && !w_deq;
    assign w_ret_dec = (w_ret_cnt != '0);

    // Entries still owed upstream; every dequeue frees one more.
    credit_counter #(.W(OW), .RST_VAL(DEPTH), .MAX(DEPTH)) u_ret_cnt (
        .i_clk(clk), .i_rst_n(reset), .i_inc(w_deq), .i_dec(w_ret_dec),
        .o_cnt(w_ret_cnt), .o_ovf(w_ret_ovf)
    );

    credit_counter #(.W(CW), .RST_VAL(0), .MAX(MAX_DN_CRED)) u_dn_cred (
        .i_clk(clk), .i_rst_n(reset), .i_inc(pre_tx_req), .i_dec(w_deq),
        .o_cnt(w_dn_cred), .o_ovf(w_dn_ovf)
    );

    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wr_ptr] <= rx_req;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_v_tx   <= 1'b0;
            r_tx     <= '0;
            r_pre_rx <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_pre_rx <= w_ret_dec;
            r_v_tx   <= w_deq;
            if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_deq) begin
                r_tx     <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_drop || w_dn_ovf || w_ret_ovf) r_err <= 1'b1;
        end
    end

    assign pre_rx_req = r_pre_rx;
    assign v_tx_req   = r_v_tx;
    assign tx_req     = r_tx;
    assign occ        = r_occ;
    assign err        = r_err;

endmodule

// File: tb/tb_req_credit_buffer.sv
// Directed bench for req_credit_buffer: queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_req_credit_buffer;
    import node_package::*;

    localparam int DEPTH = 4;
    localparam int MAXC  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v_rx_req = 1'b0;
    ReqType     rx_req = '0;
    logic       pre_rx_req;
    logic       v_tx_req;
    ReqType     tx_req;
    logic       pre_tx_req = 1'b0;
    logic [2:0] occ;
    logic       err;

    int n_cmp = 0;
    int n_fail = 0;

    req_credit_buffer #(.DEPTH(DEPTH), .MAX_DN_CRED(MAXC)) dut (
        .clk(clk), .reset(reset), .v_rx_req(v_rx_req), .rx_req(rx_req),
        .pre_rx_req(pre_rx_req), .v_tx_req(v_tx_req), .tx_req(tx_req),
        .pre_tx_req(pre_tx_req), .occ(occ), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered requests plus plain credit tallies.
    ReqType q[$];
    int     m_dn = 0, m_ret = DEPTH, nd;
    bit     m_vtx = 0, m_pre = 0, m_err = 0, md, m_full;
    ReqType m_tx = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_dn = 0; m_ret = DEPTH; m_vtx = 0; m_pre = 0; m_err = 0; m_tx = '0;
        end else begin
            md     = (q.size() != 0) && (m_dn > 0);
            m_full = (q.size() == DEPTH);
            m_vtx  = md;
            if (md) m_tx = q.pop_front();
            if (v_rx_req) begin
                if (m_full && !md) m_err = 1;
                else q.push_back(rx_req);
            end
            m_pre = (m_ret > 0);
            m_ret = m_ret - int'(m_pre) + int'(md);
            nd = m_dn + int'(pre_tx_req) - int'(md);
            if (nd > MAXC) begin nd = MAXC; m_err = 1; end
            m_dn = nd;
        end
    end

    always @(negedge clk) begin
        chk("v_tx_req", 32'(v_tx_req), 32'(m_vtx));
        chk("tx_req", 32'(tx_req), 32'(m_tx));
        chk("pre_rx_req", 32'(pre_rx_req), 32'(m_pre));
        chk("occ", 32'(occ), 32'(q.size()));
        chk("err", 32'(err), 32'(m_err));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        v_rx_req = 0; pre_tx_req = 0; rx_req = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 0;
        tick();
        reset = 1;
    endtask

    function automatic ReqType pay(input int i);
        logic [15:0] v;
        v = 16'(16'hA000 + i * 16'h0111);
        return ReqType'(v);
    endfunction

    int pre_cnt;

    initial begin
        #1 reset = 0;
        tick();
        chk("rst_occ", 32'(occ), 0);
        chk("rst_pre", 32'(pre_rx_req), 0);
        chk("rst_vtx", 32'(v_tx_req), 0);
        chk("rst_err", 32'(err), 0);
        reset = 1;

        // Initial credit burst: exactly DEPTH pulses after release.
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("burst_pre_%0d", k), 32'(pre_rx_req), (k <= 4) ? 1 : 0);
            chk("burst_occ", 32'(occ), 0);
            chk("burst_vtx", 32'(v_tx_req), 0);
        end

        // Single request with 3 credits: out at N+2, credit back at N+3.
        pre_tx_req = 1;
        repeat (3) tick();
        pre_tx_req = 0;
        v_rx_req = 1; rx_req = pay(1);
        tick();
        idle_inputs();
        chk("single_occ_n1", 32'(occ), 1);
        chk("single_vtx_n1", 32'(v_tx_req), 0);
        tick();
        chk("single_vtx_n2", 32'(v_tx_req), 1);
        chk("single_tx_n2", 32'(tx_req), 32'(pay(1)));
        chk("single_pre_n2", 32'(pre_rx_req), 0);
        tick();
        chk("single_pre_n3", 32'(pre_rx_req), 1);
        chk("single_vtx_n3", 32'(v_tx_req), 0);
        chk("single_model_dn", 32'(m_dn), 2);
        tick();
        chk("single_pre_n4", 32'(pre_rx_req), 0);

        // Fill without credits, overflow, then drain in order.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v_rx_req = 1; rx_req = pay(10 + i);
            tick();
        end
        chk("fill_occ", 32'(occ), 4);
        chk("fill_vtx", 32'(v_tx_req), 0);
        chk("fill_err", 32'(err), 0);
        rx_req = pay(99);
        tick();
        v_rx_req = 0;
        chk("ovf_err", 32'(err), 1);
        chk("ovf_occ", 32'(occ), 4);
        for (int t = 1; t <= 6; t++) begin
            pre_tx_req = (t <= 4);
            tick();
            chk($sformatf("drain_vtx_%0d", t), 32'(v_tx_req), (t >= 2 && t <= 5) ? 1 : 0);
            if (t >= 2 && t <= 5)
                chk($sformatf("drain_tx_%0d", t), 32'(tx_req), 32'(pay(10 + t - 2)));
            chk("drain_err", 32'(err), 1);
        end
        pre_tx_req = 0;

        // Streaming: continuous credits and requests.
        do_reset();
        pre_cnt = 0;
        for (int t = 0; t < 28; t++) begin
            if (t < 20) begin
                v_rx_req = 1; rx_req = pay(t); pre_tx_req = 1;
            end else begin
                idle_inputs();
            end
            tick();
            if (pre_rx_req) pre_cnt++;
            chk("stream_occ_le1", 32'(occ <= 1), 1);
            if (t >= 1 && t <= 20) begin
                chk($sformatf("stream_vtx_%0d", t), 32'(v_tx_req), 1);
                chk($sformatf("stream_tx_%0d", t), 32'(tx_req), 32'(pay(t - 1)));
            end else begin
                chk($sformatf("stream_vtx_%0d", t), 32'(v_tx_req), 0);
            end
        end
        chk("stream_pre_total", 32'(pre_cnt), 24);
        chk("stream_err", 32'(err), 0);

        // Downstream credit saturation.
        do_reset();
        pre_tx_req = 1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("sat_err_%0d", k), 32'(err), (k == 9) ? 1 : 0);
        end
        pre_tx_req = 0;
        chk("sat_model_dn", 32'(m_dn), 8);

        // Asynchronous reset mid-stream with occ=3.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            v_rx_req = 1; rx_req = pay(40 + i);
            tick();
        end
        idle_inputs();
        chk("mid_occ", 32'(occ), 3);
        chk("mid_pre", 32'(pre_rx_req), 1);
        #2 reset = 0;
        #1;
        chk("async_occ", 32'(occ), 0);
        chk("async_pre", 32'(pre_rx_req), 0);
        chk("async_vtx", 32'(v_tx_req), 0);
        chk("async_err", 32'(err), 0);
        tick();
        reset = 1;
        for (int k = 1; k <= 8; k++) begin
            pre_tx_req = (k <= 4);
            tick();
            chk($sformatf("rerst_pre_%0d", k), 32'(pre_rx_req), (k <= 4) ? 1 : 0);
            chk($sformatf("rerst_vtx_%0d", k), 32'(v_tx_req), 0);
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/req_credit_buffer.md
Name: req_credit_buffer

Overview:
- Credit-flow-controlled request buffer on the request channel, between the requesting node's request output (pre_tx_req/tx_req/v_tx_req) and the serving node's request input (pre_rx_req/rx_req/v_rx_req).
- Decouples the two nodes: absorbs up to DEPTH requests, advertises buffer space upstream as credit pulses, and forwards requests downstream only while it holds downstream credits.
- Instantiated per request link in the NoC top; the data channel is untouched.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, 2..16; also the number of credits advertised after reset.
- MAX_DN_CRED, 8, maximum downstream credits held; sizes the downstream credit counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- v_rx_req  in  1  upstream request valid; one request per cycle.
- rx_req  in  ReqType  upstream request payload, sampled when v_rx_req=1.
- pre_rx_req  out  1  upstream credit return; each cycle high = one entry freed.
- v_tx_req  out  1  downstream request valid, registered.
- tx_req  out  ReqType  downstream request payload, registered.
- pre_tx_req  in  1  downstream credit pulse; each cycle high = one credit granted.
- occ  out  $clog2(DEPTH+1)  current FIFO occupancy.
- err  out  1  sticky protocol error: overflow of FIFO or downstream credit counter.

Behaviour:
- Reset (reset=0, async) values:
  - FIFO empty; rd/wr pointers 0; occ=0.
  - v_tx_req=0, tx_req='0, pre_rx_req=0, err=0.
  - dn_cred=0.
  - ret_cnt=DEPTH, so the initial credits are returned upstream after reset.
- Upstream credit return:
  - pre_rx_req = (ret_cnt != 0), driven from the register, one pulse per cycle.
  - First cycle after reset release: pre_rx_req=1 for DEPTH consecutive cycles, unless dequeues extend the run.
  - ret_cnt next = ret_cnt − pre_rx_req + deq; simultaneous dequeue and return leaves it unchanged.
  - ret_cnt never exceeds DEPTH.
- Enqueue:
  - v_rx_req=1 in cycle N writes rx_req at wr_ptr; occ increments at the N+1 edge.
  - If FIFO is full with no dequeue in the same cycle: the flit is dropped, err←1 (sticky until reset), pointers unchanged.
- Downstream send:
  - deq = (occ != 0) && (dn_cred != 0), evaluated from registered state in cycle C.
  - On deq: tx_req←fifo[rd_ptr], v_tx_req←1 at the C+1 edge; rd_ptr++, dn_cred−−.
  - Otherwise v_tx_req←0 and tx_req holds its last value.
  - A credit arriving in cycle C is not usable until C+1.
- Latency and throughput:
  - Request enqueued in cycle N appears on v_tx_req no earlier than N+2.
  - Sustained throughput is 1 request/cycle given continuous credits.
- Simultaneous enqueue and dequeue on a full FIFO is legal: occ unchanged, no error.
- Downstream credits:
  - dn_cred next = dn_cred + pre_tx_req − deq.
  - At MAX_DN_CRED with pre_tx_req=1 and no deq: saturate, err←1.
- Pointers wrap modulo DEPTH; occ is a separate counter, not derived from the pointers.
- Reset mid-operation: in-flight FIFO contents are discarded; ret_cnt reloads to DEPTH. Both neighbour nodes share the same reset, so credit state stays consistent.

Decomposition:
- node_package holds:
  - ReqType (packed struct) and REQ_W = $bits(ReqType).
  - Default constants REQ_BUF_DEPTH=4 and REQ_MAX_CRED=8.
- One sub-module, credit_counter: up/down counter with reset value, saturation, and an overflow flag.
  - Used twice: ret_cnt (reset DEPTH, max DEPTH) and dn_cred (reset 0, max MAX_DN_CRED).
  - The FIFO storage stays inline.

Test Plan:
- Reset release, no traffic → pre_rx_req high exactly cycles 1..4 after release (DEPTH=4), then 0; occ=0, v_tx_req=0.
- 3 pre_tx_req pulses, then one v_rx_req with rx_req=A at cycle N → v_tx_req=1 with tx_req=A at N+2; pre_rx_req pulse at N+3; dn_cred=2.
- 4 back-to-back requests A..D with no downstream credits → occ=4, v_tx_req stays 0. Then a 5th request → dropped, err=1. Then 4 credit pulses → A,B,C,D emitted in order, one per cycle.
- Continuous credits plus back-to-back requests for 20 cycles → v_tx_req high every cycle after the 2-cycle fill; payload order preserved; occ ≤ 1; pre_rx_req pulses match dequeues one for one.
- 9 pre_tx_req pulses with empty FIFO and MAX_DN_CRED=8 → dn_cred saturates at 8, err=1.
- reset driven low mid-stream with occ=3 → outputs clear asynchronously in the same cycle; after release the 4-cycle pre_rx_req burst repeats and no stale request is emitted.
